// File: rtl/seg_scan_pkg.sv
// Shared types and elaboration helpers for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } scan_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int p = 1; p < value; p = p * 2) res++;
    return res;
  endfunction

  // All anodes off for an n-digit display (anodes are active-low).
  function automatic logic [63:0] an_off(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic bit params_legal(input int nd, input int dw, input int div, input int dead);
    return (nd >= 2) && (dw >= 1) && (div >= 2) && (dead >= 0) && (dead < div);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer for the scan controller: slot counter, digit index, ON/DEAD
// sequencing and the frame-start pulse.
//   state   | meaning
//   IDLE    | scanning stopped, anodes dark
//   ON      | current digit may drive its anode
//   DEAD    | tail of the slot, all anodes dark (anti-ghosting)
module scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2000,
  parameter int CNT_W       = 17,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output scan_state_e      state,
  output logic [IDX_W-1:0] idx,
  output logic             load,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam bit               HAS_DEAD  = (DEAD_CYCLES > 0);

  scan_state_e      state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= load;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    load      = 1'b0;
    advance   = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          load      = 1'b1;
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            if (HAS_DEAD) state_nxt = ST_DEAD;
            else          advance   = 1'b1;
          end
        end
        ST_DEAD: begin
          if (cnt == SLOT_LAST) advance = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
    // Wrapping past the last digit starts a new frame with a fresh snapshot.
    if (advance) begin
      state_nxt = ST_ON;
      cnt_nxt   = '0;
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
        load    = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit seven-segment scan controller: per-frame snapshot of digits and
// blank mask, leading-zero suppression and anode/digit decode.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int  NUM_DIGITS  = 4,
  parameter int  DIGIT_W     = 4,
  parameter int  REFRESH_DIV = 100000,
  parameter int  DEAD_CYCLES = 2000,
  localparam int IDX_W       = clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_en,
  output logic [DIGIT_W-1:0]            num,
  output logic [NUM_DIGITS-1:0]         an_sel,
  output logic [IDX_W-1:0]              digit_idx,
  output logic                          frame_start
);

  localparam int                   CNT_W   = clog2(REFRESH_DIV);
  localparam logic [63:0]          AN_WIDE = an_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_WIDE[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] AN_MSB = {1'b1, {(NUM_DIGITS-1){1'b0}}};

  if (!params_legal(NUM_DIGITS, DIGIT_W, REFRESH_DIV, DEAD_CYCLES)) begin : g_bad_params
    $error("seg_scan_ctrl: illegal parameter combination");
  end

  scan_state_e                   state;
  logic [IDX_W-1:0]              idx;
  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_d;
  logic [NUM_DIGITS-1:0]         snap_b;
  logic [NUM_DIGITS-1:0]         nz_from;
  logic                          nz_acc;
  logic                          suppressed;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .state       (state),
    .idx         (idx),
    .load        (load),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_d <= '0;
      snap_b <= '0;
    end else if (load) begin
      snap_d <= digits_in;
      snap_b <= blank_mask;
    end
  end

  // nz_from[i] is set when any snapshotted digit at position i or above is non-zero.
  always_comb begin
    nz_from = '0;
    nz_acc  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_acc     = nz_acc | (snap_d[i*DIGIT_W +: DIGIT_W] != '0);
      nz_from[i] = nz_acc;
    end
  end

  // lz_en is deliberately live so suppression can be toggled mid-frame.
  assign suppressed = lz_en && (idx != '0) && !nz_from[idx];
  assign digit_idx  = idx;

  always_comb begin
    num    = '0;
    an_sel = AN_OFF;
    if (state != ST_IDLE) begin
      num = snap_d[idx*DIGIT_W +: DIGIT_W];
      if ((state == ST_ON) && !snap_b[idx] && !suppressed) begin
        an_sel = ~(AN_MSB >> idx);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model checked every cycle against two
// instances (with and without dead time) plus hand-computed spot checks.
module tb_seg_scan_ctrl;

  localparam int N      = 4;
  localparam int DIV    = 4;
  localparam int TOT    = N * DIV;
  localparam int DEAD_A = 1;
  localparam int DEAD_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_en;
  logic [15:0] digits;
  logic [3:0]  blank [2];
  logic [3:0]  num_o [2];
  logic [3:0]  an_o  [2];
  logic [1:0]  idx_o [2];
  logic        fs_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_W(4), .REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits), .blank_mask(blank[0]), .lz_en(lz_en),
    .num(num_o[0]), .an_sel(an_o[0]), .digit_idx(idx_o[0]), .frame_start(fs_o[0]));

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_W(4), .REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits), .blank_mask(blank[1]), .lz_en(lz_en),
    .num(num_o[1]), .an_sel(an_o[1]), .digit_idx(idx_o[1]), .frame_start(fs_o[1]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the frame plus the frame snapshot.
  bit          m_act [2];
  int          m_pos [2];
  logic [15:0] m_sd  [2];
  logic [3:0]  m_sb  [2];
  bit          m_fs  [2];

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_act[u] <= 1'b0; m_pos[u] <= 0; m_sd[u] <= '0; m_sb[u] <= '0; m_fs[u] <= 1'b0;
      end else if (!en) begin
        m_act[u] <= 1'b0; m_pos[u] <= 0; m_fs[u] <= 1'b0;
      end else if (!m_act[u] || m_pos[u] == TOT - 1) begin
        m_act[u] <= 1'b1; m_pos[u] <= 0; m_sd[u] <= digits; m_sb[u] <= blank[u]; m_fs[u] <= 1'b1;
      end else begin
        m_pos[u] <= m_pos[u] + 1; m_fs[u] <= 1'b0;
      end
    end
  end

  function automatic void model_out(input int u, output logic [3:0] an, output logic [3:0] nm,
                                    output logic [1:0] ix);
    int  i, w, dead;
    bit  sup, lit;
    an = 4'hF; nm = 4'h0; ix = 2'd0;
    if (m_act[u]) begin
      dead = (u == 0) ? DEAD_A : DEAD_B;
      i    = m_pos[u] / DIV;
      w    = m_pos[u] % DIV;
      nm   = m_sd[u][i*4 +: 4];
      ix   = 2'(i);
      sup  = lz_en && (i >= 1) && ((m_sd[u] >> (i * 4)) == 16'h0);
      lit  = (w < DIV - dead) && !m_sb[u][i] && !sup;
      if (lit) an = ~(4'b1000 >> i);
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_an, e_num;
    logic [1:0] e_ix;
    for (int u = 0; u < 2; u++) begin
      model_out(u, e_an, e_num, e_ix);
      chk($sformatf("model_an_%0d", u),  16'(an_o[u]),  16'(e_an));
      chk($sformatf("model_num_%0d", u), 16'(num_o[u]), 16'(e_num));
      chk($sformatf("model_idx_%0d", u), 16'(idx_o[u]), 16'(e_ix));
      chk($sformatf("model_fs_%0d", u),  16'(fs_o[u]),  16'(m_fs[u]));
    end
  end

  task automatic wait_fs(input bit skip);
    bit got;
    got = 1'b0;
    if (skip) @(negedge clk);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fs_o[0]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fs_timeout got no frame_start expected one within 40 cycles");
    end
  endtask

  task automatic frame_lit(input string nm, input logic [15:0] ea, input logic [15:0] en_n);
    wait_fs(1'b1);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) repeat (4) @(negedge clk);
      chk($sformatf("%s_an%0d", nm, s),  16'(an_o[0]),  16'(ea[s*4 +: 4]));
      chk($sformatf("%s_num%0d", nm, s), 16'(num_o[0]), 16'(en_n[s*4 +: 4]));
    end
  endtask

  logic [3:0] an1 [16] = '{4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111,
                           4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
  logic [3:0] an6 [16] = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
                           4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110};

  initial begin
    rst = 1'b1; en = 1'b0; lz_en = 1'b0; digits = 16'h0;
    blank[0] = 4'b0000; blank[1] = 4'b0100;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; en = 1'b1; digits = 16'h4321;

    // basic scan, both instances
    @(negedge clk);
    chk("idle_an", 16'(an_o[0]), 16'hF);
    chk("idle_fs", 16'(fs_o[0]), 16'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("basic_an_%0d", k),  16'(an_o[0]),  16'(an1[k]));
      chk($sformatf("basic_num_%0d", k), 16'(num_o[0]), 16'(k / 4 + 1));
      chk($sformatf("basic_fs_%0d", k),  16'(fs_o[0]),  16'(k == 0));
      chk($sformatf("nodead_an_%0d", k), 16'(an_o[1]),  16'(an6[k]));
    end
    @(negedge clk);
    chk("basic_fs_repeat", 16'(fs_o[0]), 16'h1);

    // leading-zero suppression
    @(posedge clk); #2 lz_en = 1'b1; digits = 16'h0005;
    frame_lit("lz0005", 16'hFFF7, 16'h0005);
    @(posedge clk); #2 digits = 16'h0105;
    frame_lit("lz0105", 16'hFDB7, 16'h0105);

    // frame-consistent update
    @(posedge clk); #2 lz_en = 1'b0; digits = 16'h4321;
    wait_fs(1'b1);
    repeat (8) @(negedge clk);
    chk("upd_idx2", 16'(idx_o[0]), 16'h2);
    digits = 16'h9999;
    @(negedge clk);
    chk("upd_num3", 16'(num_o[0]), 16'h3);
    repeat (4) @(negedge clk);
    chk("upd_idx3", 16'(idx_o[0]), 16'h3);
    chk("upd_num4", 16'(num_o[0]), 16'h4);
    wait_fs(1'b0);
    chk("upd_num9", 16'(num_o[0]), 16'h9);

    // enable drop mid-ON of digit 1
    repeat (4) @(negedge clk);
    chk("drop_idx1", 16'(idx_o[0]), 16'h1);
    chk("drop_an1",  16'(an_o[0]),  16'hB);
    en = 1'b0;
    @(negedge clk);
    chk("drop_an",  16'(an_o[0]),  16'hF);
    chk("drop_num", 16'(num_o[0]), 16'h0);
    chk("drop_idx", 16'(idx_o[0]), 16'h0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_fs",  16'(fs_o[0]),  16'h1);
    chk("reen_idx", 16'(idx_o[0]), 16'h0);
    chk("reen_an",  16'(an_o[0]),  16'h7);

    // async reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an",  16'(an_o[0]),  16'hF);
    chk("arst_num", 16'(num_o[0]), 16'h0);
    chk("arst_idx", 16'(idx_o[0]), 16'h0);
    chk("arst_fs",  16'(fs_o[0]),  16'h0);
    digits = 16'h8765;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    wait_fs(1'b0);
    chk("arst_fresh_num", 16'(num_o[0]), 16'h5);
    chk("arst_fresh_an",  16'(an_o[0]),  16'h7);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
